imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the fetch path: the DataPath reads instructions by PC; this block writes program words into instruction memory before execution.
- Accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit words.
- Drives the instruction-memory write port at PC-compatible byte addresses.
- Raises cpu_run once the program is resident, releasing the DataPath to start fetching.

Parameters:
- ADDR_WIDTH, 8, log2 of instruction-memory depth in words (depth = 256).
- BASE_ADDR, 32'h00000000, byte address of the first loaded word.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that begins a load
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction-memory write enable
- mem_addr  out  32  byte address of the write (word aligned)
- mem_wdata  out  32  instruction word to write
- cpu_run  out  1  program loaded; DataPath may run
- busy  out  1  load in progress
- error  out  1  length exceeded memory depth
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current load

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state = IDLE;
  - all outputs = 0 (mem_addr = 0, mem_wdata = 0, words_loaded = 0);
  - any partial word and the byte counter are discarded.
- Handshake: a byte is transferred on a rising edge with in_valid && in_ready.
  - in_ready is 1 only in LEN and DATA, and is combinational from state only.
  - in_valid may drop between bytes; gaps of any length are allowed.
- Stream format:
  - 4-byte big-endian word count N;
  - then N instruction words, each 4 bytes big-endian (first byte lands in bits [31:24]).
- IDLE: start=1 → LEN; busy=1, error=0, cpu_run=0, words_loaded=0, byte counter=0.
- LEN: collect 4 bytes. On the 4th byte, transition on the same edge:
  - N=0 → DONE;
  - N > 2^ADDR_WIDTH → ERR;
  - otherwise → DATA.
- DATA: collect 4 bytes into the word shift register. The 4th byte → WRITE.
- WRITE (exactly one cycle, in_ready=0):
  - mem_we=1;
  - mem_wdata = assembled word;
  - mem_addr = BASE_ADDR + 4*words_loaded.
  - On the following edge words_loaded increments, then → DONE if words_loaded+1 == N, else → DATA.
- Timing: mem_we rises the cycle immediately after the 4th-byte handshake. Minimum 5 cycles per word.
- mem_addr and mem_wdata hold their last values outside WRITE. mem_we is 1 only in WRITE.
- DONE: cpu_run=1, busy=0; held until reset or start.
- ERR: error=1, busy=0, cpu_run=0, in_ready=0; no memory writes; held until reset or start.
- start in DONE or ERR: same action as start in IDLE; all flags cleared, and cpu_run falls on that edge.
- start while busy (LEN, DATA or WRITE): ignored.
- Reset mid-load: immediate abort. No further mem_we, and already-written words are not reverted.
- mem_addr arithmetic is modulo 2^32. With N = 2^ADDR_WIDTH the last write goes to BASE_ADDR + 4*(2^ADDR_WIDTH − 1); there is no wrap inside memory.
- words_loaded saturates naturally at N; its width holds 2^ADDR_WIDTH.

Test Plan:
- Basic load: start, then stream 00 00 00 02 20 08 00 05 20 09 00 0A with in_valid constantly high → writes 0x20080005 @0x00000000 and 0x2009000A @0x00000004; each mem_we is a one-cycle pulse; words_loaded=2; cpu_run=1 from the edge after the second write; busy=0.
- Throttled source: same stream with in_valid low for 3 cycles between every byte → identical writes and addresses; in_ready stays high during gaps; no extra mem_we.
- Zero length: start, stream 00 00 00 00 → no mem_we; DONE (cpu_run=1) the edge after the 4th byte; words_loaded=0.
- Over-length, ADDR_WIDTH=8: stream 00 00 01 01 (N=257) → error=1, in_ready=0, no mem_we, cpu_run=0; a subsequent start clears error and re-enters LEN.
- Reset mid-word: start, N=1, send 2 data bytes, assert reset asynchronously between edges → all outputs 0 immediately. After release, start with N=1 and word 8C0A0000 → single write of 0x8C0A0000 @0x0; the stale partial bytes do not appear.
- Start ignored while busy, then reload: pulse start during DATA → no state change, load completes normally. Pulse start in DONE → cpu_run drops on that edge, words_loaded=0, busy=1.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader that fills instruction memory and releases the CPU
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h00000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                cpu_run,
    output logic                busy,
    output logic                error,
    output logic [ADDR_WIDTH:0] words_loaded
);

    localparam int          CW       = ADDR_WIDTH + 1;
    localparam logic [32:0] maxWords = 33'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } loaderState_t;

    loaderState_t  state;
    logic [1:0]    byteCnt;
    logic [23:0]   shiftReg;
    logic [CW-1:0] wordTotal;

    logic [31:0]   assembled;
    logic          byteXfer;
    logic [CW-1:0] nextLoaded;
    logic [31:0]   wordOffset;

    assign in_ready   = (state == LEN) || (state == DATA);
    assign byteXfer   = in_valid && in_ready;
    // The incoming byte is the least significant one, so the word is complete on the 4th byte.
    assign assembled  = {shiftReg, in_data};
    assign nextLoaded = words_loaded + CW'(1);
    assign wordOffset = 32'(words_loaded) << 2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            byteCnt      <= 2'd0;
            shiftReg     <= 24'd0;
            wordTotal    <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            cpu_run      <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN;
                        busy         <= 1'b1;
                        error        <= 1'b0;
                        cpu_run      <= 1'b0;
                        words_loaded <= '0;
                        byteCnt      <= 2'd0;
                    end
                end
                LEN: begin
                    if (byteXfer) begin
                        shiftReg <= assembled[23:0];
                        byteCnt  <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            if (assembled == 32'd0) begin
                                state   <= DONE;
                                busy    <= 1'b0;
                                cpu_run <= 1'b1;
                            end else if ({1'b0, assembled} > maxWords) begin
                                state <= ERR;
                                busy  <= 1'b0;
                                error <= 1'b1;
                            end else begin
                                state     <= DATA;
                                wordTotal <= assembled[CW-1:0];
                            end
                        end
                    end
                end
                DATA: begin
                    if (byteXfer) begin
                        shiftReg <= assembled[23:0];
                        byteCnt  <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            state     <= WRITE;
                            mem_we    <= 1'b1;
                            mem_wdata <= assembled;
                            mem_addr  <= BASE_ADDR + wordOffset;
                        end
                    end
                end
                WRITE: begin
                    mem_we       <= 1'b0;
                    words_loaded <= nextLoaded;
                    if (nextLoaded == wordTotal) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        cpu_run <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with a queue-based write model
module tb_imem_loader;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h00000000;
    localparam int          MAXN = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          busy;
    logic          error;
    logic [AW:0]   words_loaded;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] progWords[$];
    int          compared   = 0;
    int          mismatched = 0;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .busy(busy), .error(error), .words_loaded(words_loaded)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write the DUT issues must match the next one the model predicted.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none at %0t",
                         mem_addr, mem_wdata, $time);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                check("write_addr", mem_addr, e.addr);
                check("write_data", mem_wdata, e.data);
            end
        end
    end

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!in_ready) check("handshake_timeout", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic checkReset();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_cpu_run", 32'(cpu_run), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_error", 32'(error), 0);
        check("rst_words_loaded", 32'(words_loaded), 0);
    endtask

    task automatic loadProgram(input logic [31:0] n, input int minGap, input int maxGap,
                               input int startAt, input bit givenWords);
        logic [7:0] stream[$];
        bit         fits;
        int         t;
        fits = (n <= MAXN);
        if (!givenWords) begin
            progWords.delete();
            if (fits) for (int i = 0; i < int'(n); i++) progWords.push_back($urandom);
        end
        for (int k = 3; k >= 0; k--) stream.push_back(n[8*k +: 8]);
        if (fits) begin
            for (int i = 0; i < int'(n); i++) begin
                wr_t e;
                e.addr = BASE + 32'(4 * i);
                e.data = progWords[i];
                expQ.push_back(e);
                for (int k = 3; k >= 0; k--) stream.push_back(progWords[i][8*k +: 8]);
            end
        end

        pulseStart();
        check("start_busy", 32'(busy), 1);
        check("start_cpu_run", 32'(cpu_run), 0);
        check("start_words_loaded", 32'(words_loaded), 0);
        check("start_in_ready", 32'(in_ready), 1);

        for (int i = 0; i < stream.size(); i++) begin
            int gap;
            if (i == startAt) begin
                pulseStart();
                check("start_ignored_busy", 32'(busy), 1);
                check("start_ignored_in_ready", 32'(in_ready), 1);
            end
            sendByte(stream[i]);
            if (i >= 4 && (i % 4) == 3) check("we_after_last_byte", 32'(mem_we), 1);
            gap = $urandom_range(maxGap, minGap);
            for (int g = 0; g < gap; g++) begin
                if ((i % 4) != 3) check("in_ready_in_gap", 32'(in_ready), 1);
                @(negedge clock);
            end
        end

        t = 0;
        while (busy && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("end_busy", 32'(busy), 0);
        check("end_cpu_run", 32'(cpu_run), (fits ? 1 : 0));
        check("end_error", 32'(error), (fits ? 0 : 1));
        check("end_words_loaded", 32'(words_loaded), (fits ? n : 0));
        check("end_in_ready", 32'(in_ready), 0);
        check("end_pending_writes", expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        checkReset();
        reset = 1'b0;
        @(negedge clock);

        progWords = '{32'h20080005, 32'h2009000A};
        loadProgram(2, 0, 0, -1, 1);
        loadProgram(2, 3, 3, -1, 1);
        loadProgram(0, 0, 0, -1, 0);
        loadProgram(257, 0, 1, -1, 0);
        loadProgram(MAXN, 0, 0, -1, 0);

        // Abort mid-word with an asynchronous reset between clock edges.
        pulseStart();
        sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h01);
        sendByte(8'hAB); sendByte(8'hCD);
        #2 reset = 1'b1;
        #1 checkReset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        progWords = '{32'h8C0A0000};
        loadProgram(1, 0, 0, -1, 1);

        loadProgram(3, 0, 1, 6, 0);

        for (int r = 0; r < 8; r++) loadProgram($urandom_range(6, 1), 0, 2, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
